// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 register-bank completer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package apb4_pkg;

  // Transfer phase as seen by the completer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } apb_state_e;

  // Width of the wait-state down-counter (up to 15 wait cycles).
  localparam int WAIT_CNT_W = 4;

  // Number of byte lanes on a data bus of width dw.
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  // Number of byte-offset address bits below the word index.
  function automatic int addr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb4_strb_merge.sv
// Byte-lane merge: each lane takes the write data when its strobe is set, else keeps the old value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   old_dat  current register contents
//   wr_dat   incoming write data
//   strb     per-byte write enables
//   new_dat  merged result
module apb4_strb_merge
  import apb4_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           old_dat,
  input  logic [DATA_WIDTH-1:0]           wr_dat,
  input  logic [strb_w(DATA_WIDTH)-1:0]   strb,
  output logic [DATA_WIDTH-1:0]           new_dat
);

  always_comb begin
    new_dat = old_dat;
    for (int b = 0; b < strb_w(DATA_WIDTH); b++) begin
      if (strb[b]) begin
        new_dat[b*8 +: 8] = wr_dat[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer fronting NUM_REGS word registers with byte strobes, read-only slots and PSLVERR.
// Latency: 2 + WAIT_STATES cycles per transfer (setup, WAIT_STATES wait cycles, one ready cycle).
// Backpressure: PREADY is held low for WAIT_STATES access-phase cycles; dropping PSEL aborts cleanly.
//
// Ports:
//   PCLK, PRESET                    clock and asynchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PSTRB                   APB4 requester signals
//   PRDATA, PREADY, PSLVERR         registered APB4 completer responses
//   reg_q                           flattened RW register contents (RO slots read as 0)
//   ro_in                           hardware values returned for read-only slots
module apb4_slave_regbank
  import apb4_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [strb_w(DATA_WIDTH)-1:0]  PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

  localparam int SW    = strb_w(DATA_WIDTH);
  localparam int LSB   = addr_lsb(DATA_WIDTH);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e                state;
  logic [WAIT_CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]          lat_idx;
  logic                      lat_write;
  logic                      lat_err;
  logic [DATA_WIDTH-1:0]     lat_wdata;
  logic [SW-1:0]             lat_strb;
  logic [DATA_WIDTH-1:0]     regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0]     ro_arr [NUM_REGS];

  // ---------------- address decode of the live bus (setup phase) ----------------
  // One extra bit on the subtraction: its borrow flags PADDR below BASE_ADDR.
  logic [ADDR_WIDTH:0]   diff;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      bus_idx;
  logic                  misalign;
  logic                  below;
  logic                  out_range;
  logic                  bus_err;

  assign diff      = {1'b0, PADDR} - {1'b0, BASE_ADDR};
  assign below     = diff[ADDR_WIDTH];
  assign word_off  = diff[ADDR_WIDTH-1:0] >> LSB;
  assign bus_idx   = word_off[IDX_W-1:0];
  assign misalign  = (PADDR & ADDR_WIDTH'(SW - 1)) != '0;
  assign out_range = word_off >= ADDR_WIDTH'(NUM_REGS);
  assign bus_err   = misalign | below | out_range | (PWRITE & ~out_range & RO_MASK[bus_idx]);

  // ---------------- read data for the edge that enters ACCESS ----------------
  // With no wait states the response is formed straight from the setup-phase bus;
  // otherwise from the values latched when the setup phase was seen.
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_err;
  logic                  rd_wr;
  logic [DATA_WIDTH-1:0] rd_dat;

  always_comb begin
    rd_idx = lat_idx;
    rd_err = lat_err;
    rd_wr  = lat_write;
    if (state == IDLE) begin
      rd_idx = bus_idx;
      rd_err = bus_err;
      rd_wr  = PWRITE;
    end
    rd_dat = '0;
    if (!rd_err && !rd_wr) begin
      rd_dat = RO_MASK[rd_idx] ? ro_arr[rd_idx] : regs[rd_idx];
    end
  end

  // ---------------- single commit path ----------------
  logic [DATA_WIDTH-1:0] merged;

  apb4_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_dat (regs[lat_idx]),
    .wr_dat  (lat_wdata),
    .strb    (lat_strb),
    .new_dat (merged)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign ro_arr[i]                        = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs[i];
  end

  // ---------------- transfer FSM ----------------
  // SETUP is the first access-phase cycle after capture when waits are inserted;
  // cnt holds the wait cycles still to serve, including the current one.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // Responses are single-cycle pulses; they are only raised on entry to ACCESS.
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      case (state)
        IDLE: begin
          // PENABLE without a preceding setup phase is ignored here.
          if (PSEL && !PENABLE) begin
            lat_idx   <= bus_idx;
            lat_write <= PWRITE;
            lat_err   <= bus_err;
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
            if (WAIT_STATES == 0) begin
              state   <= ACCESS;
              PREADY  <= 1'b1;
              PSLVERR <= rd_err;
              PRDATA  <= rd_dat;
            end else begin
              state <= SETUP;
              cnt   <= WAIT_CNT_W'(WAIT_STATES);
            end
          end
        end
        SETUP, WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == WAIT_CNT_W'(1)) begin
            state   <= ACCESS;
            cnt     <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= rd_err;
            PRDATA  <= rd_dat;
          end else begin
            state <= WAIT;
            cnt   <= cnt - WAIT_CNT_W'(1);
          end
        end
        ACCESS: begin
          // Commit only if the requester is still in the access phase.
          if (PSEL && PENABLE && lat_write && !lat_err) begin
            regs[lat_idx] <= merged;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
